// File: rtl/mfic_pkg.sv
`default_nettype none
// mfic_pkg: shared scheduler state encoding, channel limit and channel-index width.
package mfic_pkg;

  localparam int MFIC_NCH_MAX = 16;
  localparam int MFIC_IDX_W   = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DONE  = 2'd2
  } sched_state_t;

endpackage
`default_nettype wire

// File: rtl/mfic_next_ch.sv
`default_nettype none
// mfic_next_ch: lowest set mask bit above (or, with incl, at or above) the current index.
module mfic_next_ch
  import mfic_pkg::*;
#(
  parameter int NCH = 16
) (
  input  logic [NCH-1:0]        mask,
  input  logic [MFIC_IDX_W-1:0] cur,
  input  logic                  incl,
  output logic                  found,
  output logic [MFIC_IDX_W-1:0] idx
);

  // Descending scan so the lowest qualifying channel is the one left standing.
  always_comb begin
    found = 1'b0;
    idx   = '0;
    for (int k = NCH - 1; k >= 0; k--) begin
      if (mask[k] && ((k > int'(cur)) || (incl && (k == int'(cur))))) begin
        found = 1'b1;
        idx   = MFIC_IDX_W'(k);
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/mfic_chan_sched.sv
`default_nettype none
// mfic_chan_sched: captures a frame of channel samples on strobe and issues enabled channels in
// ascending order over a ready/valid port. Defining MFIC_SCHED_MASK_EN adds a per-frame ch_mask input.
module mfic_chan_sched
  import mfic_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int NCH   = 16
) (
  input  logic                  clk,
  input  logic                  reset_b,
  input  logic                  strobe,
  input  logic [NCH*WIDTH-1:0]  in_bus,
  input  logic                  ch_ready,
  input  logic                  ovr_clr,
`ifdef MFIC_SCHED_MASK_EN
  input  logic [NCH-1:0]        ch_mask,
`endif
  output logic [WIDTH-1:0]      ch_data,
  output logic [MFIC_IDX_W-1:0] ch_idx,
  output logic                  ch_valid,
  output logic                  ch_first,
  output logic                  ch_last,
  output logic                  busy,
  output logic                  frame_done,
  output logic                  ovr,
  output logic [15:0]           frame_cnt
);

  sched_state_t            state_q, state_d;
  logic [NCH*WIDTH-1:0]    bank_q;
  logic [WIDTH-1:0]        data_q;
  logic [MFIC_IDX_W-1:0]   idx_q;
  logic                    first_q;
  logic                    ovr_q;
  logic [15:0]             cnt_q;

  logic                    capture, advance;
  logic [NCH-1:0]          cap_mask, run_mask;
  logic                    first_found, nxt_found;
  logic [MFIC_IDX_W-1:0]   first_idx, nxt_idx;

`ifdef MFIC_SCHED_MASK_EN
  logic [NCH-1:0] mask_q;

  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b)     mask_q <= '0;
    else if (capture) mask_q <= ch_mask;
  end

  assign cap_mask = ch_mask;
  assign run_mask = mask_q;
`else
  assign cap_mask = '1;
  assign run_mask = '1;
`endif

  mfic_next_ch #(.NCH(NCH)) u_first (
    .mask  (cap_mask),
    .cur   ({MFIC_IDX_W{1'b0}}),
    .incl  (1'b1),
    .found (first_found),
    .idx   (first_idx)
  );

  mfic_next_ch #(.NCH(NCH)) u_next (
    .mask  (run_mask),
    .cur   (idx_q),
    .incl  (1'b0),
    .found (nxt_found),
    .idx   (nxt_idx)
  );

  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    capture = 1'b0;
    advance = 1'b0;
    case (state_q)
      IDLE: begin
        if (strobe) begin
          capture = 1'b1;
          state_d = first_found ? ISSUE : DONE;
        end
      end
      ISSUE: begin
        if (ch_ready) begin
          advance = 1'b1;
          if (!nxt_found) state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      bank_q  <= '0;
      data_q  <= '0;
      idx_q   <= '0;
      first_q <= 1'b0;
    end else if (capture) begin
      bank_q  <= in_bus;
      data_q  <= in_bus[int'(first_idx)*WIDTH +: WIDTH];
      idx_q   <= first_idx;
      first_q <= 1'b1;
    end else if (advance && nxt_found) begin
      data_q  <= bank_q[int'(nxt_idx)*WIDTH +: WIDTH];
      idx_q   <= nxt_idx;
      first_q <= 1'b0;
    end
  end

  // An overrun strobe takes priority over a same-cycle clear.
  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b)                        ovr_q <= 1'b0;
    else if (strobe && state_q != IDLE)  ovr_q <= 1'b1;
    else if (ovr_clr)                    ovr_q <= 1'b0;
  end

  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b)            cnt_q <= '0;
    else if (state_q == DONE) cnt_q <= cnt_q + 16'd1;
  end

  assign ch_valid   = (state_q == ISSUE);
  assign ch_data    = data_q;
  assign ch_idx     = idx_q;
  assign ch_first   = ch_valid & first_q;
  assign ch_last    = ch_valid & ~nxt_found;
  assign busy       = (state_q != IDLE);
  assign frame_done = (state_q == DONE);
  assign ovr        = ovr_q;
  assign frame_cnt  = cnt_q;

endmodule
`default_nettype wire
